traffic_light_monitor: RTL

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/traffic_pkg.sv | 47 ++++
 rtl/tl_lamp_decoder.sv | 28 ++
 rtl/traffic_light_monitor.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types, timing limits and phase helpers for the traffic light monitor.
package traffic_pkg;

    localparam int DWELL_W = 8;
    localparam logic [DWELL_W-1:0] MIN_GREEN  = 8'd11;
    localparam logic [DWELL_W-1:0] MIN_YELLOW = 8'd4;
    localparam logic [DWELL_W-1:0] MAX_DWELL  = 8'd15;
    localparam int FLASH_HALF = 8;
    localparam int FLASH_W    = $clog2(FLASH_HALF);

    typedef enum logic [1:0] {
        NS_GREEN  = 2'd0,
        NS_YELLOW = 2'd1,
        EW_GREEN  = 2'd2,
        EW_YELLOW = 2'd3
    } phase_t;

    typedef enum logic [2:0] {
        FC_NONE         = 3'd0,
        FC_ILLEGAL      = 3'd1,
        FC_BAD_SEQ      = 3'd2,
        FC_SHORT_GREEN  = 3'd3,
        FC_SHORT_YELLOW = 3'd4,
        FC_WATCHDOG     = 3'd5
    } fault_code_t;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } mon_state_t;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            NS_GREEN:  return NS_YELLOW;
            NS_YELLOW: return EW_GREEN;
            EW_GREEN:  return EW_YELLOW;
            default:   return NS_GREEN;
        endcase
    endfunction

    function automatic logic is_green(input phase_t p);
        return (p == NS_GREEN) || (p == EW_GREEN);
    endfunction

endpackage

// File: rtl/tl_lamp_decoder.sv
// Combinational map of the six observed lamp drives to a phase plus a legal flag.
module tl_lamp_decoder
    import traffic_pkg::*;
(
    input  logic   ns_red,
    input  logic   ns_yel,
    input  logic   ns_grn,
    input  logic   ew_red,
    input  logic   ew_yel,
    input  logic   ew_grn,
    output phase_t phase,
    output logic   legal
);

    always_comb begin
        phase = NS_GREEN;
        legal = 1'b1;
        // Exactly two lamps lit, one per direction; everything else is illegal.
        case ({ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn})
            6'b001_100: phase = NS_GREEN;
            6'b010_100: phase = NS_YELLOW;
            6'b100_001: phase = EW_GREEN;
            6'b100_010: phase = EW_YELLOW;
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light sequence monitor: latches the first fault and requests all-red.
// Optional all-red flash output is built only when TLM_FLASH_EN is defined.
module traffic_light_monitor
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ns_red,
    input  logic       ns_yel,
    input  logic       ns_grn,
    input  logic       ew_red,
    input  logic       ew_yel,
    input  logic       ew_grn,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       safe_req,
    output logic       flash,
    output logic [7:0] cycle_count,
    output logic [1:0] dbg_state
);

    phase_t               dec_phase;
    logic                 dec_legal;
    mon_state_t           state_q, state_d;
    phase_t               phase_q, phase_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d, dwell_inc;
    logic                 fault_q, fault_d;
    fault_code_t          code_q, code_d, code_det;
    logic                 safe_q, safe_d;
    logic [7:0]           count_q, count_d;

    tl_lamp_decoder u_dec (
        .ns_red (ns_red),
        .ns_yel (ns_yel),
        .ns_grn (ns_grn),
        .ew_red (ew_red),
        .ew_yel (ew_yel),
        .ew_grn (ew_grn),
        .phase  (dec_phase),
        .legal  (dec_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            phase_q <= NS_GREEN;
            dwell_q <= '0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
            safe_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            dwell_q <= dwell_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            safe_q  <= safe_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        dwell_d   = dwell_q;
        fault_d   = fault_q;
        code_d    = code_q;
        safe_d    = safe_q;
        count_d   = count_q;
        code_det  = FC_NONE;
        dwell_inc = (dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1;

        case (state_q)
            ST_INIT: begin
                if (!dec_legal) begin
                    code_det = FC_ILLEGAL;
                end else begin
                    phase_d = dec_phase;
                    dwell_d = 8'd1;
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC, ST_RUN: begin
                // Priority order of this chain yields the lowest code on a tie.
                if (!dec_legal) begin
                    code_det = FC_ILLEGAL;
                end else if (dec_phase == phase_q) begin
                    dwell_d = dwell_inc;
                    if (phase_q != NS_GREEN && dwell_inc == MAX_DWELL + 8'd1)
                        code_det = FC_WATCHDOG;
                end else if (dec_phase != next_phase(phase_q)) begin
                    code_det = FC_BAD_SEQ;
                end else if (state_q == ST_RUN && is_green(phase_q) && dwell_q < MIN_GREEN) begin
                    code_det = FC_SHORT_GREEN;
                end else if (state_q == ST_RUN && !is_green(phase_q) && dwell_q < MIN_YELLOW) begin
                    code_det = FC_SHORT_YELLOW;
                end else begin
                    if (state_q == ST_RUN && phase_q == EW_YELLOW)
                        count_d = count_q + 8'd1;
                    phase_d = dec_phase;
                    dwell_d = 8'd1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (fault_clr) begin
                    state_d = ST_INIT;
                    fault_d = 1'b0;
                    code_d  = FC_NONE;
                    safe_d  = 1'b0;
                    dwell_d = '0;
                end
            end
        endcase

        if (code_det != FC_NONE) begin
            fault_d = 1'b1;
            code_d  = code_det;
            safe_d  = 1'b1;
            state_d = ST_FAULT;
        end
    end

`ifdef TLM_FLASH_EN
    logic [FLASH_W-1:0] flash_cnt_q;
    logic               flash_q;

    // Flash starts lit on fault entry and toggles every FLASH_HALF cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_cnt_q <= '0;
            flash_q     <= 1'b0;
        end else if (state_q != ST_FAULT || state_d != ST_FAULT) begin
            flash_cnt_q <= '0;
            flash_q     <= (state_q != ST_FAULT) && (state_d == ST_FAULT);
        end else if (flash_cnt_q == FLASH_W'(FLASH_HALF - 1)) begin
            flash_cnt_q <= '0;
            flash_q     <= ~flash_q;
        end else begin
            flash_cnt_q <= flash_cnt_q + 1'b1;
        end
    end

    assign flash = flash_q;
`else
    assign flash = 1'b0;
`endif

    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign safe_req    = safe_q;
    assign cycle_count = count_q;
    assign dbg_state   = state_q;

endmodule
